// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF and MEM stage), the unified
// memory and the port arbiter. The slave view belongs to the arbiter. The
// master view belongs to the pipeline-plus-memory side that drives requests
// and read data.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;
    // Data side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_stall;
    // Memory side
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_cancel, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
               mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_cancel, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
               mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the fetch and data sides of the pipeline.
// The data side wins ties because it belongs to the older instruction. Each
// access holds mem_valid for MEM_LATENCY cycles. A one-cycle DONE state
// follows, in which the ready pulse lets the pipeline advance and drop its
// request before the next grant. A squashed fetch still runs its full memory
// transaction, but it ends silently and goes straight back to IDLE.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic              grant_d, grant_i, cap_i, cap_d;
    logic              side_d_q;      // 1 when the current/last access is the data side
    logic              acc_we_q;
    logic [ADDR_W-1:0] acc_addr_q;
    logic [DATA_W-1:0] acc_wdata_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, grant decision, beat counting and capture strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        grant_d = 1'b0;
        grant_i = 1'b0;
        cap_i   = 1'b0;
        cap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req) begin
                    grant_d = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = BUSY_D;
                end else if (bus.if_req && !bus.if_cancel) begin
                    grant_i = 1'b1;
                    cnt_d   = LAT_M1;
                    drop_d  = 1'b0;
                    state_d = BUSY_I;
                end
            end
            BUSY_I: begin
                if (bus.if_cancel) drop_d = 1'b1;
                if (cnt_q == '0) begin
                    // A squash in the final beat still suppresses the result
                    if (drop_q || bus.if_cancel) begin
                        state_d = IDLE;
                    end else begin
                        cap_i   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BUSY_D: begin
                if (cnt_q == '0) begin
                    cap_d   = !acc_we_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access latches, counter, squash flag and returned-data holding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            side_d_q    <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            if (grant_d) begin
                side_d_q    <= 1'b1;
                acc_we_q    <= bus.d_we;
                acc_addr_q  <= bus.d_addr;
                acc_wdata_q <= bus.d_wdata;
            end else if (grant_i) begin
                side_d_q    <= 1'b0;
                acc_we_q    <= 1'b0;
                acc_addr_q  <= bus.if_addr;
            end
            if (cap_i) if_rdata_q <= bus.mem_rdata;
            if (cap_d) d_rdata_q  <= bus.mem_rdata;
        end
    end

    // Memory drive comes straight from state and latches, so reset kills it at once
    assign bus.mem_valid = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign bus.mem_we    = (state_q == BUSY_D) && acc_we_q;
    assign bus.mem_addr  = acc_addr_q;
    assign bus.mem_wdata = acc_wdata_q;

    assign bus.if_ready  = (state_q == DONE) && !side_d_q;
    assign bus.d_ready   = (state_q == DONE) &&  side_d_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req && !bus.if_ready;
    assign bus.d_stall   = bus.d_req  && !bus.d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two DUTs (MEM_LATENCY 2 and 1) share one
// stimulus stream. For each DUT, a transaction-level model predicts the
// outputs of every cycle from the grant time, the access window and the ready
// cycle. Directed literal checks pin the latencies and data of the plan.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, if_cancel = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic [1:0]        mv_w, mwe_w, ifr_w, dr_w;
    logic [1:0][31:0]  maddr_w, mwd_w, ifd_w, dd_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: two planted words, everything else derived from the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0000_0100: memfn = 32'h0050_0093;
            32'h0000_2000: memfn = 32'hDEAD_BEEF;
            default:       memfn = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int LAT = (g == 0) ? 2 : 1;

        mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        assign bus.if_req    = if_req;
        assign bus.if_addr   = if_addr;
        assign bus.if_cancel = if_cancel;
        assign bus.d_req     = d_req;
        assign bus.d_we      = d_we;
        assign bus.d_addr    = d_addr;
        assign bus.d_wdata   = d_wdata;
        assign bus.mem_rdata = memfn(bus.mem_addr);

        mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign mv_w[g]    = bus.mem_valid;
        assign mwe_w[g]   = bus.mem_we;
        assign maddr_w[g] = bus.mem_addr;
        assign mwd_w[g]   = bus.mem_wdata;
        assign ifr_w[g]   = bus.if_ready;
        assign dr_w[g]    = bus.d_ready;
        assign ifd_w[g]   = bus.if_rdata;
        assign dd_w[g]    = bus.d_rdata;

        // Current transaction: granted in cycle s, memory busy s+1..s+LAT, ready at s+LAT+1
        bit          have = 1'b0, dropped = 1'b0, t_d = 1'b0, t_we = 1'b0;
        int          t_end = 0;
        logic [31:0] t_addr = '0, t_wdata = '0, e_if = '0, e_d = '0;

        always @(negedge clk) begin : model
            bit act, rdy, idle;
            if (reset) begin
                have = 1'b0;
                e_if = '0;
                e_d  = '0;
            end
            act = have && (cyc >= t_end - LAT + 1) && (cyc <= t_end);
            rdy = have && !dropped && (cyc == t_end + 1);
            if (rdy && t_d && !t_we) e_d  = memfn(t_addr);
            if (rdy && !t_d)         e_if = memfn(t_addr);

            chk($sformatf("L%0d mem_valid", LAT), bus.mem_valid, act);
            chk($sformatf("L%0d mem_we", LAT), bus.mem_we, act && t_d && t_we);
            if (act) chk($sformatf("L%0d mem_addr", LAT), bus.mem_addr, t_addr);
            if (act && t_we) chk($sformatf("L%0d mem_wdata", LAT), bus.mem_wdata, t_wdata);
            chk($sformatf("L%0d if_ready", LAT), bus.if_ready, rdy && !t_d);
            chk($sformatf("L%0d d_ready", LAT), bus.d_ready, rdy && t_d);
            chk($sformatf("L%0d if_rdata", LAT), bus.if_rdata, e_if);
            chk($sformatf("L%0d d_rdata", LAT), bus.d_rdata, e_d);
            chk($sformatf("L%0d if_stall", LAT), bus.if_stall, if_req && !(rdy && !t_d));
            chk($sformatf("L%0d d_stall", LAT), bus.d_stall, d_req && !(rdy && t_d));

            if (act && !t_d && if_cancel) dropped = 1'b1;
            idle = !have || (cyc > (dropped ? t_end : t_end + 1));
            if (!reset && idle) begin
                if (d_req) begin
                    have = 1'b1; dropped = 1'b0; t_d = 1'b1; t_we = d_we;
                    t_addr = d_addr; t_wdata = d_wdata; t_end = cyc + LAT;
                end else if (if_req && !if_cancel) begin
                    have = 1'b1; dropped = 1'b0; t_d = 1'b0; t_we = 1'b0;
                    t_addr = if_addr; t_end = cyc + LAT;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int g, input bit side_d, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (side_d ? dr_w[g] : ifr_w[g]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_rdy g%0d side_d=%0d: no ready within %0d cycles", g, side_d, maxc);
        end
    endtask

    initial begin
        int t0, at;
        // Reset state
        tick(); tick();
        for (int g = 0; g < 2; g++) begin
            chk("rst mem_valid", mv_w[g], 1'b0);
            chk("rst mem_addr", maddr_w[g], 32'h0);
            chk("rst mem_wdata", mwd_w[g], 32'h0);
            chk("rst if_rdata", ifd_w[g], 32'h0);
            chk("rst d_rdata", dd_w[g], 32'h0);
        end
        reset = 1'b0;

        // 1: plain fetch
        tick(); t0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        wait_rdy(0, 1'b0, 20, at);
        chk("t1 if latency", at - t0, 3);
        chk("t1 if_rdata", ifd_w[0], 32'h0050_0093);
        if_req = 1'b0;
        repeat (4) tick();

        // 2: simultaneous requests, data first
        tick(); t0 = cyc;
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick();
        chk("t2 mem_addr c1", maddr_w[0], 32'h2000);
        wait_rdy(0, 1'b1, 20, at);
        chk("t2 d latency", at - t0, 3);
        chk("t2 d_rdata", dd_w[0], 32'hDEAD_BEEF);
        d_req = 1'b0;
        wait_rdy(0, 1'b0, 20, at);
        chk("t2 if latency", at - t0, 7);
        chk("t2 if_rdata", ifd_w[0], 32'hA5A5_0104);
        if_req = 1'b0;
        repeat (4) tick();

        // 3: store
        tick(); t0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'h1234_5678;
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk("t3 mem_we", mwe_w[0], 1'b1);
            chk("t3 mem_addr", maddr_w[0], 32'h2004);
            chk("t3 mem_wdata", mwd_w[0], 32'h1234_5678);
        end
        wait_rdy(0, 1'b1, 20, at);
        chk("t3 d latency", at - t0, 3);
        chk("t3 d_rdata kept", dd_w[0], 32'hDEAD_BEEF);
        d_req = 1'b0; d_we = 1'b0;
        repeat (4) tick();

        // 4: squashed fetch, then a fresh fetch
        tick(); t0 = cyc;
        if_req = 1'b1; if_addr = 32'h108;
        tick(); if_cancel = 1'b1;
        chk("t4 mem_valid c1", mv_w[0], 1'b1);
        tick(); if_cancel = 1'b0;
        chk("t4 mem_valid c2", mv_w[0], 1'b1);
        tick();
        chk("t4 no if_ready c3", ifr_w[0], 1'b0);
        chk("t4 idle c3", mv_w[0], 1'b0);
        if_addr = 32'h10C;
        wait_rdy(0, 1'b0, 20, at);
        chk("t4 refetch ready", at - t0, 6);
        chk("t4 if_rdata", ifd_w[0], 32'hA5A5_010C);
        if_req = 1'b0;
        repeat (4) tick();

        // 5: asynchronous reset during a store
        tick(); t0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2008; d_wdata = 32'hCAFE_F00D;
        tick();
        chk("t5 store active", mwe_w[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t5 rst mem_valid", mv_w[0], 1'b0);
        chk("t5 rst mem_we", mwe_w[0], 1'b0);
        chk("t5 rst mem_addr", maddr_w[0], 32'h0);
        chk("t5 rst mem_wdata", mwd_w[0], 32'h0);
        chk("t5 rst d_rdata", dd_w[0], 32'h0);
        chk("t5 rst if_rdata", ifd_w[0], 32'h0);
        chk("t5 rst d_ready", dr_w[0], 1'b0);
        d_req = 1'b0; d_we = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); t0 = cyc;
        if_req = 1'b1; if_addr = 32'h110;
        wait_rdy(0, 1'b0, 20, at);
        chk("t5 post-reset latency", at - t0, 3);
        chk("t5 if_rdata", ifd_w[0], 32'hA5A5_0110);
        if_req = 1'b0;
        repeat (4) tick();

        // 6: MEM_LATENCY=1, back-to-back loads
        tick(); t0 = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        wait_rdy(1, 1'b1, 20, at);
        chk("t6 ready 1", at - t0, 2);
        chk("t6 rdata 1", dd_w[1], 32'hA5A5_3000);
        d_addr = 32'h3004;
        wait_rdy(1, 1'b1, 20, at);
        chk("t6 ready 2", at - t0, 5);
        chk("t6 rdata 2", dd_w[1], 32'hA5A5_3004);
        d_addr = 32'h3008;
        wait_rdy(1, 1'b1, 20, at);
        chk("t6 ready 3", at - t0, 8);
        chk("t6 rdata 3", dd_w[1], 32'hA5A5_3008);
        d_req = 1'b0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
